// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared channel state, channel count and counter sizing
package button_conditioner_pkg;

    localparam int NUM_BTNS = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_REPEAT  = 2'd2
    } chan_state_e;

    // Wide enough to hold the largest of the three timing parameters, plus a spare bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// rtl/button_conditioner_channel.sv - one button: 2-flop sync, debouncer and press/repeat FSM
module btn_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw_i,
    output logic pulse_o,
    output logic pulse_nxt_o,
    output logic level_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
    localparam logic [CW-1:0] DB_MAX    = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DELAY_END = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_END  = CW'(REPEAT_RATE - 1);

    logic [1:0]    sync_q,    sync_d;
    logic [CW-1:0] db_cnt_q,  db_cnt_d;
    logic [CW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          level_q,   level_d;
    logic          pulse_q,   pulse_d;
    chan_state_e   state_q,   state_d;

    always_comb begin
        sync_d = {sync_q[0], raw_i};

        level_d  = level_q;
        db_cnt_d = '0;
        if (db_cnt_q == DB_MAX) begin
            level_d  = ~level_q;
        end else if (sync_q[1] != level_q) begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // FSM looks at the next level so the press pulse lands with the level rise
    // and a release always wins over a repeat that would fall on the same edge.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        pulse_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rpt_cnt_d = '0;
                if (level_d && !level_q) begin
                    state_d = ST_PRESSED;
                    pulse_d = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!level_d) begin
                    state_d   = ST_IDLE;
                    rpt_cnt_d = '0;
                end else if (REPEAT_EN && rpt_cnt_q >= DELAY_END && !pulse_q) begin
                    state_d   = ST_REPEAT;
                    pulse_d   = 1'b1;
                    rpt_cnt_d = '0;
                end else if (REPEAT_EN) begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (!level_d) begin
                    state_d   = ST_IDLE;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q >= RATE_END && !pulse_q) begin
                    pulse_d   = 1'b1;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                rpt_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q    <= '0;
            db_cnt_q  <= '0;
            rpt_cnt_q <= '0;
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
            state_q   <= ST_IDLE;
        end else begin
            sync_q    <= sync_d;
            db_cnt_q  <= db_cnt_d;
            rpt_cnt_q <= rpt_cnt_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            state_q   <= state_d;
        end
    end

    assign pulse_o     = pulse_q;
    assign pulse_nxt_o = pulse_d;
    assign level_o     = level_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - seven independent debounced buttons with press pulse and auto-repeat
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int                    DEBOUNCE_CYCLES = 1000000,
    parameter int                    REPEAT_DELAY    = 50000000,
    parameter int                    REPEAT_RATE     = 10000000,
    parameter logic [NUM_BTNS-1:0]   REPEAT_MASK     = 7'b0000111
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NUM_BTNS-1:0] btnRaw,
    output logic [NUM_BTNS-1:0] btnPulse,
    output logic [NUM_BTNS-1:0] btnLevel,
    output logic                anyPress
);

    logic [NUM_BTNS-1:0] pulse_nxt;
    logic                any_press_q, any_press_d;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_chan (
            .CLK         (CLK),
            .RST         (RST),
            .raw_i       (btnRaw[i]),
            .pulse_o     (btnPulse[i]),
            .pulse_nxt_o (pulse_nxt[i]),
            .level_o     (btnLevel[i])
        );
    end

    // Registered from the channels' next-pulse terms so it lines up with btnPulse.
    always_comb begin
        any_press_d = |pulse_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= any_press_d;
        end
    end

    assign anyPress = any_press_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed bench for button_conditioner
module tb_button_conditioner;

    logic       CLK = 1'b0;
    logic       RST;
    logic [6:0] btnRaw;
    logic [6:0] btnPulse;
    logic [6:0] btnLevel;
    logic       anyPress;

    int n_cmp = 0;
    int n_err = 0;

    int         ev_t[$];
    int         ev_b[$];
    int         any_t[$];
    logic [6:0] lvl_hist [0:127];

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_RATE     (8),
        .REPEAT_MASK     (7'b0000111)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .btnRaw   (btnRaw),
        .btnPulse (btnPulse),
        .btnLevel (btnLevel),
        .anyPress (anyPress)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_log();
        ev_t.delete();
        ev_b.delete();
        any_t.delete();
        for (int i = 0; i < 128; i++) lvl_hist[i] = '0;
    endtask

    task automatic step(input int t);
        tick();
        for (int b = 0; b < 7; b++) begin
            if (btnPulse[b]) begin
                ev_t.push_back(t);
                ev_b.push_back(b);
            end
        end
        if (anyPress) any_t.push_back(t);
        lvl_hist[t] = btnLevel;
    endtask

    function automatic int n_pulses(input int b);
        int n = 0;
        foreach (ev_b[i]) if (ev_b[i] == b) n++;
        return n;
    endfunction

    function automatic int pulse_at(input int b, input int k);
        int n = 0;
        foreach (ev_b[i]) begin
            if (ev_b[i] == b) begin
                if (n == k) return ev_t[i];
                n++;
            end
        end
        return -1;
    endfunction

    task automatic do_reset();
        RST    = 1'b1;
        btnRaw = '0;
        tick();
        tick();
        RST = 1'b0;
        clear_log();
    endtask

    initial begin
        int exp0[6];
        int lvl_seen;
        exp0 = '{6, 26, 34, 42, 50, 58};

        // reset holds everything low even with all buttons pressed
        RST    = 1'b1;
        btnRaw = 7'h7f;
        for (int i = 0; i < 8; i++) tick();
        check("rst_pulse", int'(btnPulse), 0);
        check("rst_level", int'(btnLevel), 0);
        check("rst_any",   int'(anyPress), 0);

        // single press on non-repeating bit 3, held 100 cycles
        do_reset();
        for (int t = 0; t < 120; t++) begin
            btnRaw = (t < 100) ? 7'b0001000 : 7'b0;
            step(t);
        end
        check("b3_count",   n_pulses(3), 1);
        check("b3_time",    pulse_at(3, 0), 6);
        check("b3_any_cnt", any_t.size(), 1);
        check("b3_lvl5",    int'(lvl_hist[5][3]), 0);
        check("b3_lvl6",    int'(lvl_hist[6][3]), 1);
        check("b3_lvl105",  int'(lvl_hist[105][3]), 1);
        check("b3_lvl106",  int'(lvl_hist[106][3]), 0);

        // auto-repeat on bit 0, held 60 cycles; release must not add a pulse
        do_reset();
        for (int t = 0; t < 80; t++) begin
            btnRaw = (t < 60) ? 7'b0000001 : 7'b0;
            step(t);
        end
        check("b0_count", n_pulses(0), 6);
        for (int k = 0; k < 6; k++) check($sformatf("b0_pulse%0d", k), pulse_at(0, k), exp0[k]);
        check("b0_lvl65", int'(lvl_hist[65][0]), 1);
        check("b0_lvl66", int'(lvl_hist[66][0]), 0);

        // bit 1 bouncing every 2 cycles never qualifies
        do_reset();
        for (int t = 0; t < 40; t++) begin
            btnRaw = (t < 30 && ((t / 2) % 2 == 0)) ? 7'b0000010 : 7'b0;
            step(t);
        end
        lvl_seen = 0;
        for (int t = 0; t < 40; t++) if (lvl_hist[t][1]) lvl_seen++;
        check("b1_count", n_pulses(1), 0);
        check("b1_level", lvl_seen, 0);

        // bits 0 and 5 together
        do_reset();
        for (int t = 0; t < 20; t++) begin
            btnRaw = (t < 10) ? 7'b0100001 : 7'b0;
            step(t);
        end
        check("b05_p0",      pulse_at(0, 0), 6);
        check("b05_p5",      pulse_at(5, 0), 6);
        check("b05_any_cnt", any_t.size(), 1);
        check("b05_any_t",   (any_t.size() > 0) ? any_t[0] : -1, 6);

        // reset in the middle of a bit-2 press, button still held afterwards
        do_reset();
        for (int t = 0; t < 30; t++) begin
            RST    = (t >= 3 && t < 10);
            btnRaw = 7'b0000100;
            step(t);
        end
        RST = 1'b0;
        check("b2_count",  n_pulses(2), 1);
        check("b2_time",   pulse_at(2, 0), 16);
        check("b2_lvl9",   int'(lvl_hist[9][2]), 0);
        check("b2_lvl16",  int'(lvl_hist[16][2]), 1);

        // bit 4 release with a 2-cycle glitch high right after release
        do_reset();
        for (int t = 0; t < 40; t++) begin
            btnRaw = (t < 20 || t == 21 || t == 22) ? 7'b0010000 : 7'b0;
            step(t);
        end
        check("b4_count", n_pulses(4), 1);
        check("b4_time",  pulse_at(4, 0), 6);
        check("b4_lvl28", int'(lvl_hist[28][4]), 1);
        check("b4_lvl29", int'(lvl_hist[29][4]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, means consecutive stable cycles required to accept a level change; legal range is >=1.
REQ-002 Parameter REPEAT_DELAY, default 50000000, means cycles from the first press pulse to the first auto-repeat pulse; legal range is >=1.
REQ-003 Parameter REPEAT_RATE, default 10000000, means cycles between later auto-repeat pulses; legal range is >=1.
REQ-004 Parameter REPEAT_MASK, default 7'b0000111, means a 1 enables auto-repeat for that bit.
REQ-005 Port CLK, input, width 1: the single clock; all state updates on its rising edge.
REQ-006 Port RST, input, width 1: synchronous, active-high reset.
REQ-007 Port btnRaw, input, width 7: raw asynchronous push-button levels, 1 = pressed.
REQ-008 Port btnPulse, output, width 7: one-CLK pulse per accepted press or auto-repeat.
REQ-009 Port btnLevel, output, width 7: debounced button level.
REQ-010 Port anyPress, output, width 1: OR of btnPulse.

Function
REQ-011 Each bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-012 Each channel SHALL hold a debounce counter. The counter counts up while the synchronized input differs from btnLevel and clears to 0 on any cycle where they match.
REQ-013 When the counter reaches DEBOUNCE_CYCLES, btnLevel SHALL toggle on the next edge and the counter SHALL clear.
REQ-014 On a clean raw rise, btnPulse SHALL first assert exactly DEBOUNCE_CYCLES+2 cycles after the edge that samples btnRaw high, in the same cycle btnLevel rises.
REQ-015 Any bounce shorter than DEBOUNCE_CYCLES SHALL restart the count and produce no pulse and no level change.
REQ-016 Each channel SHALL implement this state machine:
  - IDLE to PRESSED when the level rises (pulse emitted).
  - PRESSED to REPEAT when the level is held for REPEAT_DELAY cycles after the press pulse and the mask bit is 1 (pulse emitted).
  - REPEAT emits a pulse every REPEAT_RATE cycles while held.
  - PRESSED or REPEAT to IDLE when the level falls.
REQ-017 Release SHALL be debounced identically to press and SHALL generate no pulse.
REQ-018 A channel whose mask bit is 0 SHALL emit exactly one pulse per accepted press, however long the button is held.
REQ-019 btnPulse SHALL never be high on two consecutive cycles for the same bit.
REQ-020 Channels SHALL be fully independent; simultaneous presses SHALL produce pulses in the same cycle on each bit.
REQ-021 The repeat counter SHALL saturate-free wrap: it reloads to 0 on every pulse and on release, and never overflows.
REQ-022 Counter widths SHALL be $clog2 of the largest parameter plus 1.

Reset
REQ-023 While RST=1, synchronizer flops, btnLevel, btnPulse, anyPress and all counters SHALL be 0 and every channel SHALL be in IDLE.
REQ-024 A button held across reset deassertion SHALL be treated as a new press: one pulse, DEBOUNCE_CYCLES+2 cycles after the first post-reset edge.
REQ-025 Reset asserted mid-debounce or mid-repeat SHALL abort with no pulse emitted.

Structure
REQ-026 A shared package SHALL hold the channel-state enum (IDLE, PRESSED, REPEAT), the channel count constant (7) and the counter-width function.
REQ-027 Sub-module btn_channel SHALL implement one synchronizer, debouncer and FSM. The top SHALL instantiate seven copies and pass each its mask bit.
REQ-028 Outputs SHALL be registered, with no combinational path from btnRaw to any output.

Verification
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.
REQ-029 Bit 3 rises clean and is held 100 cycles: exactly one btnPulse[3], 6 cycles after the sampling edge; btnLevel[3]=1 until release is debounced.
REQ-030 Bit 0 is held 60 cycles: pulses at t=6, 26, 34, 42, 50, 58, with t counted from the sampling edge.
REQ-031 Bit 1 toggles every 2 cycles for 30 cycles, then is held low: no pulse, btnLevel[1] stays 0.
REQ-032 Bits 0 and 5 rise on the same edge: both pulses in the same cycle, and anyPress=1 for that single cycle.
REQ-033 RST is asserted at t=3 of a bit-2 press and released at t=10 with the button still held: no pulse before reset, one pulse 6 cycles after the first post-reset edge.
REQ-034 Bit 4 is released with a 2-cycle glitch high at release t+1: btnLevel[4] falls 6 cycles after the final stable low, and no extra pulse appears.
